// File: rtl/trap_if.sv
// Commit-stage / CSR-file bundle around the trap sequencer: event inputs,
// current CSR values, the exception write bundle and the fetch redirect.
interface trap_if;
  logic        valid_i;
  logic [31:0] pc_i;
  logic [31:0] instr_i;
  logic [31:0] badaddr_i;
  logic        exc_inst_misaligned_i;
  logic        exc_illegal_i;
  logic        exc_ebreak_i;
  logic        exc_ecall_i;
  logic        exc_load_misaligned_i;
  logic        exc_store_misaligned_i;
  logic        mret_i;
  logic        irq_timer_i;
  logic [31:0] mtvec_i;
  logic [31:0] mepc_i;
  logic [31:0] mcause_i;
  logic [31:0] mstatus_i;
  logic [31:0] mie_i;
  logic        we_exc_o;
  logic [31:0] mcause_o;
  logic [31:0] mepc_o;
  logic [31:0] mtval_o;
  logic [31:0] mstatus_o;
  logic        flush_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        busy_o;

  modport master (
    output valid_i, pc_i, instr_i, badaddr_i,
           exc_inst_misaligned_i, exc_illegal_i, exc_ebreak_i, exc_ecall_i,
           exc_load_misaligned_i, exc_store_misaligned_i, mret_i, irq_timer_i,
           mtvec_i, mepc_i, mcause_i, mstatus_i, mie_i,
    input  we_exc_o, mcause_o, mepc_o, mtval_o, mstatus_o,
           flush_o, redirect_o, redirect_pc_o, busy_o
  );

  modport slave (
    input  valid_i, pc_i, instr_i, badaddr_i,
           exc_inst_misaligned_i, exc_illegal_i, exc_ebreak_i, exc_ecall_i,
           exc_load_misaligned_i, exc_store_misaligned_i, mret_i, irq_timer_i,
           mtvec_i, mepc_i, mcause_i, mstatus_i, mie_i,
    output we_exc_o, mcause_o, mepc_o, mtval_o, mstatus_o,
           flush_o, redirect_o, redirect_pc_o, busy_o
  );
endinterface

// File: rtl/trap_unit.sv
// Trap/MRET sequencer: IDLE accepts one event, COMMIT strobes the CSR
// exception write and flush, REDIRECT steers fetch to mtvec or mepc.
module trap_unit #(
   parameter bit MTVAL_EN    = 1'b1,
   parameter bit VECTORED_EN = 1'b1
) (
   input logic   clk_i,
   input logic   rst_i,
   trap_if.slave bus
);

   typedef enum logic [1:0] {IDLE, COMMIT, REDIRECT} state_e;

   state_e      state_q, state_d;
   logic        exc_hit, irq_take, accept, is_mret;
   logic [31:0] cause, mtval, mstatus_nx;
   logic [31:0] mcause_q, mepc_q, mtval_q, mstatus_q;
   logic        mret_q, vec_q;
   logic [31:0] target;

   // Event decode; the if/else order is the architectural priority.
   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      exc_hit  = 1'b1;
      cause    = 32'd0;
      mtval    = 32'd0;
      if (bus.exc_inst_misaligned_i) begin
         cause = 32'd0;
         mtval = bus.badaddr_i;
      end else if (bus.exc_illegal_i) begin
         cause = 32'd2;
         mtval = bus.instr_i;
      end else if (bus.exc_ebreak_i) begin
         cause = 32'd3;
      end else if (bus.exc_ecall_i) begin
         cause = 32'd11;
      end else if (bus.exc_load_misaligned_i) begin
         cause = 32'd4;
         mtval = bus.badaddr_i;
      end else if (bus.exc_store_misaligned_i) begin
         cause = 32'd6;
         mtval = bus.badaddr_i;
      end else begin
         exc_hit = 1'b0;
         cause   = 32'h8000_0007;
      end
      if (!MTVAL_EN) mtval = 32'd0;

      irq_take = bus.irq_timer_i & bus.mie_i[7] & bus.mstatus_i[3];
      is_mret  = !exc_hit && !irq_take && bus.mret_i;
      accept   = (state_q == IDLE) && bus.valid_i && (exc_hit || irq_take || bus.mret_i);

      mstatus_nx = bus.mstatus_i;
      mstatus_nx[12:11] = 2'b11;
      if (is_mret) begin
         mstatus_nx[3] = bus.mstatus_i[7];
         mstatus_nx[7] = 1'b1;
      end else begin
         mstatus_nx[7] = bus.mstatus_i[3];
         mstatus_nx[3] = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (accept) state_d = COMMIT;
         COMMIT:   state_d = REDIRECT;
         REDIRECT: state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q   <= IDLE;
         mcause_q  <= 32'd0;
         mepc_q    <= 32'd0;
         mtval_q   <= 32'd0;
         mstatus_q <= 32'd0;
         mret_q    <= 1'b0;
         vec_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            mstatus_q <= mstatus_nx;
            mret_q    <= is_mret;
            vec_q     <= VECTORED_EN && !exc_hit && irq_take;
            if (is_mret) begin
               mcause_q <= bus.mcause_i;
               mepc_q   <= bus.mepc_i;
               mtval_q  <= 32'd0;
            end else begin
               mcause_q <= cause;
               mepc_q   <= {bus.pc_i[31:2], 2'b00};
               mtval_q  <= exc_hit ? mtval : 32'd0;
            end
         end
      end
   end

   // Target reads mtvec/mepc live in REDIRECT, after the COMMIT-cycle CSR write.
   always_comb begin
      target = mret_q ? {bus.mepc_i[31:2], 2'b00} : {bus.mtvec_i[31:2], 2'b00};
      if (vec_q && bus.mtvec_i[1:0] == 2'b01) target = target + 32'h0000_001C;
   end

   assign bus.we_exc_o      = (state_q == COMMIT);
   assign bus.flush_o       = (state_q == COMMIT);
   assign bus.redirect_o    = (state_q == REDIRECT);
   assign bus.busy_o        = (state_q != IDLE);
   assign bus.redirect_pc_o = (state_q == REDIRECT) ? target : 32'd0;
   assign bus.mcause_o      = mcause_q;
   assign bus.mepc_o        = mepc_q;
   assign bus.mtval_o       = mtval_q;
   assign bus.mstatus_o     = mstatus_q;

endmodule

// File: tb/tb_trap_unit.sv
// Directed bench for trap_unit: table of single-event sequences plus
// hand-written busy-masking and mid-sequence reset scenarios.
module tb_trap_unit;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  trap_if bus ();

  trap_unit #(.MTVAL_EN(1'b1), .VECTORED_EN(1'b1)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // exc = {inst_mis, illegal, ebreak, ecall, load_mis, store_mis}
  typedef struct {
    logic        valid;
    logic [5:0]  exc;
    logic        mret;
    logic        irq;
    logic [31:0] pc, instr, badaddr, mtvec, mepc, mcause, mstatus, mie;
    logic        taken;
    logic [31:0] e_mcause, e_mepc, e_mtval, e_mstatus, e_rpc;
  } vec_t;

  vec_t vecs[13];

  task automatic clear_events();
    bus.valid_i = 1'b0;
    {bus.exc_inst_misaligned_i, bus.exc_illegal_i, bus.exc_ebreak_i,
     bus.exc_ecall_i, bus.exc_load_misaligned_i, bus.exc_store_misaligned_i} = 6'b0;
    bus.mret_i      = 1'b0;
    bus.irq_timer_i = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    bus.valid_i = v.valid;
    {bus.exc_inst_misaligned_i, bus.exc_illegal_i, bus.exc_ebreak_i,
     bus.exc_ecall_i, bus.exc_load_misaligned_i, bus.exc_store_misaligned_i} = v.exc;
    bus.mret_i      = v.mret;
    bus.irq_timer_i = v.irq;
    bus.pc_i        = v.pc;
    bus.instr_i     = v.instr;
    bus.badaddr_i   = v.badaddr;
    bus.mtvec_i     = v.mtvec;
    bus.mepc_i      = v.mepc;
    bus.mcause_i    = v.mcause;
    bus.mstatus_i   = v.mstatus;
    bus.mie_i       = v.mie;
  endtask

  function automatic vec_t mk(logic valid, logic [5:0] exc, logic mret, logic irq,
                              logic [31:0] pc, logic [31:0] instr, logic [31:0] badaddr,
                              logic [31:0] mtvec, logic [31:0] mepc, logic [31:0] mcause,
                              logic [31:0] mstatus, logic [31:0] mie, logic taken,
                              logic [31:0] e_mcause, logic [31:0] e_mepc, logic [31:0] e_mtval,
                              logic [31:0] e_mstatus, logic [31:0] e_rpc);
    vec_t v;
    v.valid = valid; v.exc = exc; v.mret = mret; v.irq = irq;
    v.pc = pc; v.instr = instr; v.badaddr = badaddr; v.mtvec = mtvec;
    v.mepc = mepc; v.mcause = mcause; v.mstatus = mstatus; v.mie = mie;
    v.taken = taken; v.e_mcause = e_mcause; v.e_mepc = e_mepc; v.e_mtval = e_mtval;
    v.e_mstatus = e_mstatus; v.e_rpc = e_rpc;
    return v;
  endfunction

  int pulses;

  initial begin
    //            vld exc        mret irq pc          instr         badaddr       mtvec         mepc          mcause        mstatus       mie    tkn  e_mcause      e_mepc        e_mtval       e_mstatus     e_rpc
    vecs[0]  = mk(1, 6'b010000, 0, 0, 32'h0000_0104, 32'hFFFF_FFFF, 32'h0,        32'h0000_0200, 32'h0,        32'h0,        32'h0000_0008, 32'h0,  1, 32'd2,         32'h0000_0104, 32'hFFFF_FFFF, 32'h0000_1880, 32'h0000_0200);
    vecs[1]  = mk(1, 6'b000110, 1, 0, 32'h0000_0208, 32'h0000_0073, 32'h0000_1003, 32'h0000_0200, 32'h0000_0500, 32'h0,        32'h0000_0008, 32'h0,  1, 32'd11,        32'h0000_0208, 32'h0,        32'h0000_1880, 32'h0000_0200);
    vecs[2]  = mk(1, 6'b000000, 0, 1, 32'h0000_0300, 32'h0,        32'h0,        32'h0000_0401, 32'h0,        32'h0,        32'h0000_0008, 32'h80, 1, 32'h8000_0007, 32'h0000_0300, 32'h0,        32'h0000_1880, 32'h0000_041C);
    vecs[3]  = mk(1, 6'b000000, 0, 1, 32'h0000_0300, 32'h0,        32'h0,        32'h0000_0401, 32'h0,        32'h0,        32'h0000_0000, 32'h80, 0, 32'h0,         32'h0,         32'h0,        32'h0,         32'h0);
    vecs[4]  = mk(1, 6'b000000, 1, 0, 32'h0000_0400, 32'h0,        32'h0,        32'h0000_0200, 32'h0000_0108, 32'h0000_0002, 32'h0000_1880, 32'h0,  1, 32'h0000_0002, 32'h0000_0108, 32'h0,        32'h0000_1888, 32'h0000_0108);
    vecs[5]  = mk(1, 6'b110000, 0, 0, 32'h0000_0402, 32'h0000_0013, 32'h0000_0402, 32'h0000_0203, 32'h0,        32'h0,        32'h0000_0000, 32'h0,  1, 32'd0,         32'h0000_0400, 32'h0000_0402, 32'h0000_1800, 32'h0000_0200);
    vecs[6]  = mk(1, 6'b000001, 0, 0, 32'h0000_0010, 32'h0,        32'h0000_1001, 32'h0000_0401, 32'h0,        32'h0,        32'h0000_0088, 32'h0,  1, 32'd6,         32'h0000_0010, 32'h0000_1001, 32'h0000_1880, 32'h0000_0400);
    vecs[7]  = mk(1, 6'b001000, 0, 1, 32'h0000_0020, 32'h0010_0073, 32'h0,        32'h0000_0101, 32'h0,        32'h0,        32'h0000_0008, 32'h80, 1, 32'd3,         32'h0000_0020, 32'h0,        32'h0000_1880, 32'h0000_0100);
    vecs[8]  = mk(1, 6'b000010, 0, 0, 32'h0000_0030, 32'h0,        32'h0000_2002, 32'h0000_0300, 32'h0,        32'h0,        32'h0000_0000, 32'h0,  1, 32'd4,         32'h0000_0030, 32'h0000_2002, 32'h0000_1800, 32'h0000_0300);
    vecs[9]  = mk(0, 6'b010000, 0, 0, 32'h0000_0040, 32'hFFFF_FFFF, 32'h0,        32'h0000_0200, 32'h0,        32'h0,        32'h0000_0008, 32'h0,  0, 32'h0,         32'h0,         32'h0,        32'h0,         32'h0);
    vecs[10] = mk(1, 6'b000000, 0, 1, 32'h0000_0050, 32'h0,        32'h0,        32'h0000_0401, 32'h0,        32'h0,        32'h0000_0008, 32'h0,  0, 32'h0,         32'h0,         32'h0,        32'h0,         32'h0);
    vecs[11] = mk(1, 6'b000000, 1, 0, 32'h0000_0060, 32'h0,        32'h0,        32'h0000_0200, 32'h0000_010B, 32'h8000_0007, 32'h0000_0000, 32'h0,  1, 32'h8000_0007, 32'h0000_010B, 32'h0,        32'h0000_1880, 32'h0000_0108);
    vecs[12] = mk(1, 6'b000000, 0, 1, 32'h0000_0074, 32'h0,        32'h0,        32'h0000_0400, 32'h0,        32'h0,        32'h0000_1808, 32'h80, 1, 32'h8000_0007, 32'h0000_0074, 32'h0,        32'h0000_1880, 32'h0000_0400);

    drive(vecs[0]);
    clear_events();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("reset we_exc",   {31'd0, bus.we_exc_o},   32'd0);
    check("reset flush",    {31'd0, bus.flush_o},    32'd0);
    check("reset redirect", {31'd0, bus.redirect_o}, 32'd0);
    check("reset busy",     {31'd0, bus.busy_o},     32'd0);
    check("reset mcause",   bus.mcause_o,            32'd0);
    check("reset mstatus",  bus.mstatus_o,           32'd0);
    check("reset rpc",      bus.redirect_pc_o,       32'd0);
    rst_i = 1'b1;

    for (int i = 0; i < 13; i++) begin
      @(negedge clk_i);
      drive(vecs[i]);
      @(negedge clk_i);                       // cycle E+1
      clear_events();
      check($sformatf("v%0d we_exc", i), {31'd0, bus.we_exc_o}, {31'd0, vecs[i].taken});
      check($sformatf("v%0d flush", i),  {31'd0, bus.flush_o},  {31'd0, vecs[i].taken});
      check($sformatf("v%0d busy1", i),  {31'd0, bus.busy_o},   {31'd0, vecs[i].taken});
      if (vecs[i].taken) begin
        check($sformatf("v%0d mcause", i),  bus.mcause_o,  vecs[i].e_mcause);
        check($sformatf("v%0d mepc", i),    bus.mepc_o,    vecs[i].e_mepc);
        check($sformatf("v%0d mtval", i),   bus.mtval_o,   vecs[i].e_mtval);
        check($sformatf("v%0d mstatus", i), bus.mstatus_o, vecs[i].e_mstatus);
      end
      @(negedge clk_i);                       // cycle E+2
      check($sformatf("v%0d redirect", i), {31'd0, bus.redirect_o}, {31'd0, vecs[i].taken});
      check($sformatf("v%0d we_exc2", i),  {31'd0, bus.we_exc_o},   32'd0);
      check($sformatf("v%0d busy2", i),    {31'd0, bus.busy_o},     {31'd0, vecs[i].taken});
      if (vecs[i].taken)
        check($sformatf("v%0d rpc", i), bus.redirect_pc_o, vecs[i].e_rpc);
      @(negedge clk_i);                       // back in IDLE
      check($sformatf("v%0d idle busy", i), {31'd0, bus.busy_o},     32'd0);
      check($sformatf("v%0d idle redir", i), {31'd0, bus.redirect_o}, 32'd0);
    end

    // Exception held across COMMIT/REDIRECT: masked there, re-accepted in IDLE.
    @(negedge clk_i);
    drive(vecs[0]);
    pulses = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk_i);
      if (bus.we_exc_o) pulses++;
      check($sformatf("hold we_exc c%0d", c), {31'd0, bus.we_exc_o},
            (c == 1 || c == 4) ? 32'd1 : 32'd0);
      if (c == 2) bus.pc_i = 32'h0000_0800;   // change while masked
      if (c == 4) begin
        check("hold mepc second", bus.mepc_o, 32'h0000_0800);
        clear_events();
      end
    end
    check("hold pulse count", pulses, 32'd2);

    // Reset during COMMIT abandons the sequence.
    @(negedge clk_i);
    drive(vecs[4]);
    @(negedge clk_i);
    clear_events();
    check("rst pre we_exc", {31'd0, bus.we_exc_o}, 32'd1);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rst we_exc",   {31'd0, bus.we_exc_o},   32'd0);
    check("rst redirect", {31'd0, bus.redirect_o}, 32'd0);
    check("rst busy",     {31'd0, bus.busy_o},     32'd0);
    check("rst mstatus",  bus.mstatus_o,           32'd0);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("rst no redirect", {31'd0, bus.redirect_o}, 32'd0);
    check("rst no busy",     {31'd0, bus.busy_o},     32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
